// File: rtl/sad_pkg.sv
// Shared definitions for the SAD stereo datapath.
//   pixel_col_t   : 3-row pixel column, [0]=row y-1, [1]=row y, [2]=row y+1
//   feed_state_t  : column-feeder FSM states
//   DEF_*         : default frame geometry shared with the SAD window unit
//   idx_width()   : index width for a count of n items (minimum 1 bit)
package sad_pkg;

    typedef logic [2:0][7:0] pixel_col_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DRAIN,
        ST_DONE
    } feed_state_t;

    localparam int unsigned DEF_IMG_WIDTH  = 320;
    localparam int unsigned DEF_IMG_HEIGHT = 240;
    localparam int unsigned DEF_MAX_DISP   = 16;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sad_tag_pipe.sv
// Fixed-depth shift register carrying the valid flag and beat tags so they
// stay aligned with data returned by a fixed-latency buffer.
//   i_clk, i_rst : clock, synchronous active-high reset (clears every stage)
//   i_tag        : tag word entering stage 0
//   o_tag        : tag word DEPTH cycles later
module sad_tag_pipe #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_tag,
    output logic [WIDTH-1:0] o_tag
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/sad_column_feeder.sv
// Sweeps a rectified stereo pair held in column line buffers and emits, per
// centre row y and disparity d, the left column at x and the right column at
// x-d (zero when x<d) as one tagged beat per cycle.
//   clk_in, rst_in         : clock, synchronous active-high reset
//   start_in               : begin a frame sweep (honoured only in IDLE)
//   left/right_rd_*_out    : buffer read strobe and column/row address
//   left/right_col_in      : buffer data, BRAM_LATENCY cycles after strobe
//   left_out, right_out    : column beat
//   data_valid_out, x_out, y_out, disp_out, row_start_out : beat valid/tags
//   busy_out, done_out     : sweep/drain in progress, end-of-frame pulse
module sad_column_feeder
    import sad_pkg::*;
#(
    parameter int unsigned IMG_WIDTH    = DEF_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT   = DEF_IMG_HEIGHT,
    parameter int unsigned MAX_DISP     = DEF_MAX_DISP,
    parameter int unsigned BRAM_LATENCY = 2,
    localparam int unsigned X_W = idx_width(IMG_WIDTH),
    localparam int unsigned Y_W = idx_width(IMG_HEIGHT),
    localparam int unsigned D_W = idx_width(MAX_DISP)
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           start_in,
    output logic           left_rd_en_out,
    output logic [X_W-1:0] left_rd_x_out,
    output logic [Y_W-1:0] left_rd_y_out,
    input  pixel_col_t     left_col_in,
    output logic           right_rd_en_out,
    output logic [X_W-1:0] right_rd_x_out,
    output logic [Y_W-1:0] right_rd_y_out,
    input  pixel_col_t     right_col_in,
    output pixel_col_t     left_out,
    output pixel_col_t     right_out,
    output logic           data_valid_out,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic [D_W-1:0] disp_out,
    output logic           row_start_out,
    output logic           busy_out,
    output logic           done_out
);

    localparam int unsigned TAG_W = 3 + D_W + Y_W + X_W;
    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 2);
    localparam logic [D_W-1:0] D_LAST = D_W'(MAX_DISP - 1);

    feed_state_t    r_state;
    logic [X_W-1:0] r_x, r_rx;
    logic [Y_W-1:0] r_y;
    logic [D_W-1:0] r_d;
    logic           r_iss, r_ren, r_busy, r_done;

    logic [X_W-1:0] w_nx, w_rx;
    logic [Y_W-1:0] w_ny;
    logic [D_W-1:0] w_nd;
    logic           w_last, w_nzero;

    // r_x/r_y/r_d hold the position being issued this cycle; w_n* is the next one.
    always_comb begin
        w_nx = r_x + 1'b1;
        w_nd = r_d;
        w_ny = r_y;
        if (r_x == X_LAST) begin
            w_nx = '0;
            if (r_d == D_LAST) begin
                w_nd = '0;
                w_ny = r_y + 1'b1;
            end else begin
                w_nd = r_d + 1'b1;
            end
        end
    end

    assign w_last  = (r_x == X_LAST) && (r_d == D_LAST) && (r_y == Y_LAST);
    assign w_nzero = (32'(w_nx) < 32'(w_nd));
    assign w_rx    = w_nx - X_W'(w_nd);

    logic [TAG_W-1:0] w_tag_in, w_tag_out;
    logic             w_t_valid, w_t_zero, w_t_rs;
    logic [D_W-1:0]   w_t_d;
    logic [Y_W-1:0]   w_t_y;
    logic [X_W-1:0]   w_t_x;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_d     <= '0;
            r_rx    <= '0;
            r_iss   <= 1'b0;
            r_ren   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start_in) begin
                        r_state <= ST_SWEEP;
                        r_busy  <= 1'b1;
                        r_x     <= '0;
                        r_y     <= Y_W'(1);
                        r_d     <= '0;
                        r_rx    <= '0;
                        r_iss   <= 1'b1;
                        r_ren   <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (w_last) begin
                        r_state <= ST_DRAIN;
                        r_iss   <= 1'b0;
                        r_ren   <= 1'b0;
                    end else begin
                        r_x   <= w_nx;
                        r_y   <= w_ny;
                        r_d   <= w_nd;
                        r_rx  <= w_rx;
                        r_ren <= ~w_nzero;
                    end
                end
                ST_DRAIN: begin
                    // Last beat is on the outputs and nothing valid remains in flight.
                    if (data_valid_out && !w_t_valid) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_tag_in = {r_iss, r_iss & ~r_ren, r_iss & (r_x == '0), r_d, r_y, r_x};

    sad_tag_pipe #(
        .DEPTH (BRAM_LATENCY),
        .WIDTH (TAG_W)
    ) u_tag_pipe (
        .i_clk (clk_in),
        .i_rst (rst_in),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    assign {w_t_valid, w_t_zero, w_t_rs, w_t_d, w_t_y, w_t_x} = w_tag_out;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            data_valid_out <= 1'b0;
            left_out       <= '0;
            right_out      <= '0;
            x_out          <= '0;
            y_out          <= '0;
            disp_out       <= '0;
            row_start_out  <= 1'b0;
        end else begin
            data_valid_out <= w_t_valid;
            left_out       <= w_t_valid ? left_col_in : '0;
            right_out      <= (w_t_valid && !w_t_zero) ? right_col_in : '0;
            x_out          <= w_t_x;
            y_out          <= w_t_y;
            disp_out       <= w_t_d;
            row_start_out  <= w_t_rs;
        end
    end

    assign left_rd_en_out  = r_iss;
    assign left_rd_x_out   = r_x;
    assign left_rd_y_out   = r_y;
    assign right_rd_en_out = r_ren;
    assign right_rd_x_out  = r_rx;
    assign right_rd_y_out  = r_y;
    assign busy_out        = r_busy;
    assign done_out        = r_done;

endmodule

// File: tb/tb_sad_column_feeder.sv
// Scoreboard bench for sad_column_feeder: W=8, H=4, MAX_DISP=2, L=2.
module tb_sad_column_feeder;
    import sad_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 4;
    localparam int unsigned MD = 2;
    localparam int unsigned L  = 2;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       start_in = 1'b0;
    logic       left_rd_en_out, right_rd_en_out;
    logic [2:0] left_rd_x_out, right_rd_x_out, x_out;
    logic [1:0] left_rd_y_out, right_rd_y_out, y_out;
    logic [0:0] disp_out;
    pixel_col_t left_col_in, right_col_in, left_out, right_out;
    logic       data_valid_out, row_start_out, busy_out, done_out;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        int         x;
        int         y;
        int         d;
        logic       rs;
        pixel_col_t l;
        pixel_col_t r;
    } beat_t;

    typedef struct {
        int x;
        int y;
        int d;
    } iss_t;

    beat_t beat_q[$];
    iss_t  iss_q[$];

    pixel_col_t lq [L];
    pixel_col_t rq [L];

    sad_column_feeder #(
        .IMG_WIDTH    (W),
        .IMG_HEIGHT   (H),
        .MAX_DISP     (MD),
        .BRAM_LATENCY (L)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start_in        (start_in),
        .left_rd_en_out  (left_rd_en_out),
        .left_rd_x_out   (left_rd_x_out),
        .left_rd_y_out   (left_rd_y_out),
        .left_col_in     (left_col_in),
        .right_rd_en_out (right_rd_en_out),
        .right_rd_x_out  (right_rd_x_out),
        .right_rd_y_out  (right_rd_y_out),
        .right_col_in    (right_col_in),
        .left_out        (left_out),
        .right_out       (right_out),
        .data_valid_out  (data_valid_out),
        .x_out           (x_out),
        .y_out           (y_out),
        .disp_out        (disp_out),
        .row_start_out   (row_start_out),
        .busy_out        (busy_out),
        .done_out        (done_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic pixel_col_t col(input int x, input int y);
        pixel_col_t c;
        for (int r = 0; r < 3; r++) begin
            c[r] = {4'(y - 1 + r), 4'(x)};
        end
        return c;
    endfunction

    // Buffer models: data visible L cycles after the strobe; junk when not strobed.
    always @(posedge clk_in) begin
        lq[0] <= left_rd_en_out  ? col(int'(left_rd_x_out),  int'(left_rd_y_out))  : 24'hDEADBE;
        rq[0] <= right_rd_en_out ? col(int'(right_rd_x_out), int'(right_rd_y_out)) : 24'hDEADBE;
        for (int i = 1; i < L; i++) begin
            lq[i] <= lq[i-1];
            rq[i] <= rq[i-1];
        end
    end
    assign left_col_in  = lq[L-1];
    assign right_col_in = rq[L-1];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame();
        beat_t b;
        iss_t  s;
        for (int y = 1; y <= int'(H) - 2; y++) begin
            for (int d = 0; d < int'(MD); d++) begin
                for (int x = 0; x < int'(W); x++) begin
                    b.x  = x;
                    b.y  = y;
                    b.d  = d;
                    b.rs = (x == 0);
                    b.l  = col(x, y);
                    b.r  = (x >= d) ? col(x - d, y) : '0;
                    beat_q.push_back(b);
                    s.x = x;
                    s.y = y;
                    s.d = d;
                    iss_q.push_back(s);
                end
            end
        end
    endtask

    // Beat and read-issue monitor, sampling on the falling edge.
    always @(negedge clk_in) begin
        if (data_valid_out === 1'b1) begin
            if (beat_q.size() == 0) begin
                check_eq("unexpected_beat", data_valid_out, 0);
            end else begin
                beat_t e;
                e = beat_q.pop_front();
                check_eq("beat_x",  x_out,         e.x);
                check_eq("beat_y",  y_out,         e.y);
                check_eq("beat_d",  disp_out,      e.d);
                check_eq("beat_rs", row_start_out, e.rs);
                check_eq("beat_l",  left_out,      e.l);
                check_eq("beat_r",  right_out,     e.r);
                check_eq("beat_busy", busy_out,    1);
            end
        end
        if (left_rd_en_out === 1'b1) begin
            if (iss_q.size() == 0) begin
                check_eq("unexpected_issue", left_rd_en_out, 0);
            end else begin
                iss_t s;
                s = iss_q.pop_front();
                check_eq("iss_lx",  left_rd_x_out,   s.x);
                check_eq("iss_ly",  left_rd_y_out,   s.y);
                check_eq("iss_ren", right_rd_en_out, s.x >= s.d);
                if (s.x >= s.d) begin
                    check_eq("iss_rx", right_rd_x_out, s.x - s.d);
                    check_eq("iss_ry", right_rd_y_out, s.y);
                end
            end
        end else if (right_rd_en_out === 1'b1) begin
            check_eq("stray_right_strobe", right_rd_en_out, 0);
        end
    end

    task automatic run_sweep(input int unsigned abort_at);
        int unsigned k;
        int unsigned nbeats;
        int unsigned extra;
        push_frame();
        @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        check_eq("first_issue", left_rd_en_out, 1);
        check_eq("busy_start",  busy_out,       1);
        k = 1;
        while (data_valid_out !== 1'b1 && k < 20) begin
            @(negedge clk_in);
            k++;
        end
        check_eq("first_beat_lat", k, 4);
        nbeats = 0;
        while (data_valid_out === 1'b1 && nbeats < 64) begin
            nbeats++;
            start_in = (nbeats == 6);
            if (abort_at != 0 && nbeats == abort_at) begin
                rst_in = 1'b1;
                @(negedge clk_in);
                rst_in = 1'b0;
                check_eq("abort_valid", data_valid_out,  0);
                check_eq("abort_busy",  busy_out,        0);
                check_eq("abort_done",  done_out,        0);
                check_eq("abort_lrd",   left_rd_en_out,  0);
                check_eq("abort_rrd",   right_rd_en_out, 0);
                check_eq("abort_left",  left_out,        0);
                beat_q.delete();
                iss_q.delete();
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk_in);
                    check_eq("abort_no_done",  done_out,       0);
                    check_eq("abort_no_valid", data_valid_out, 0);
                end
                return;
            end
            @(negedge clk_in);
        end
        check_eq("beat_count",   nbeats,   32);
        check_eq("done_pulse",   done_out, 1);
        check_eq("busy_in_done", busy_out, 0);
        check_eq("sb_empty",     beat_q.size(), 0);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        check_eq("done_single", done_out, 0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            if (data_valid_out === 1'b1 || busy_out === 1'b1) extra++;
            @(negedge clk_in);
        end
        check_eq("no_second_sweep", extra, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk_in);
        check_eq("rst_valid", data_valid_out,  0);
        check_eq("rst_busy",  busy_out,        0);
        check_eq("rst_done",  done_out,        0);
        check_eq("rst_lrd",   left_rd_en_out,  0);
        check_eq("rst_rrd",   right_rd_en_out, 0);
        check_eq("rst_left",  left_out,        0);
        check_eq("rst_right", right_out,       0);
        check_eq("rst_tags",  {x_out, y_out, disp_out, row_start_out}, 0);
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        check_eq("idle_busy", busy_out, 0);

        run_sweep(0);
        run_sweep(10);
        run_sweep(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
